psk_modulator: RTL and testbench

//  Parametrised M-PSK baseband modulator, successor to the fixed BPSK chain.

---
 rtl/psk_modulator.sv | 243 ++++++++++++++++++++++++
 tb/tb_psk_modulator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/psk_modulator.sv
// M-PSK baseband modulator: serialises words MSB first into BPSK/QPSK/8PSK symbols
// and emits one Gray-mapped sine cycle (16*OSR samples) per symbol.
module psk_modulator #(
    parameter int DATA_W = 8,
    parameter int OSR    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] parallel_in,
    input  logic              load,
    input  logic [1:0]        mode,
    output logic              ready,
    output logic [7:0]        mod_out,
    output logic              mod_valid,
    output logic [2:0]        sym_out,
    output logic              sym_start,
    output logic              busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] OSR_M1 = 4'(OSR - 1);
    localparam logic [5:0] NSYM1  = 6'(DATA_W);
    localparam logic [5:0] NSYM2  = 6'((DATA_W + 1) / 2);
    localparam logic [5:0] NSYM3  = 6'((DATA_W + 2) / 3);

    function automatic logic [1:0] bps_of(input logic [1:0] m);
        case (m)
            2'b01:   return 2'd2;
            2'b10:   return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    function automatic logic [5:0] nsym_of(input logic [1:0] b);
        case (b)
            2'd2:    return NSYM2;
            2'd3:    return NSYM3;
            default: return NSYM1;
        endcase
    endfunction

    // Two zero bits appended so a short final 8PSK symbol is padded in its LSBs.
    function automatic logic [2:0] sym_of(input logic [DATA_W-1:0] w, input logic [1:0] b);
        logic [DATA_W+1:0] wp;
        wp = {w, 2'b00};
        case (b)
            2'd2:    return {1'b0, wp[DATA_W+1 -: 2]};
            2'd3:    return wp[DATA_W+1 -: 3];
            default: return {2'b00, wp[DATA_W+1]};
        endcase
    endfunction

    function automatic logic [3:0] phase_of(input logic [2:0] s, input logic [1:0] b);
        if (b == 2'd2) begin
            case (s[1:0])
                2'b00:   return 4'd0;
                2'b01:   return 4'd4;
                2'b11:   return 4'd8;
                default: return 4'd12;
            endcase
        end else if (b == 2'd3) begin
            case (s)
                3'b000:  return 4'd0;
                3'b001:  return 4'd2;
                3'b011:  return 4'd4;
                3'b010:  return 4'd6;
                3'b110:  return 4'd8;
                3'b111:  return 4'd10;
                3'b101:  return 4'd12;
                default: return 4'd14;
            endcase
        end else begin
            return s[0] ? 4'd8 : 4'd0;
        end
    endfunction

    function automatic logic [7:0] lut(input logic [3:0] i);
        case (i)
            4'd0:    return 8'd128;
            4'd1:    return 8'd177;
            4'd2:    return 8'd218;
            4'd3:    return 8'd245;
            4'd4:    return 8'd255;
            4'd5:    return 8'd245;
            4'd6:    return 8'd218;
            4'd7:    return 8'd177;
            4'd8:    return 8'd128;
            4'd9:    return 8'd79;
            4'd10:   return 8'd38;
            4'd11:   return 8'd11;
            4'd12:   return 8'd1;
            4'd13:   return 8'd11;
            4'd14:   return 8'd38;
            default: return 8'd79;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, hold_q, hold_d;
    logic [1:0]        bps_q, bps_d, hold_mode_q, hold_mode_d;
    logic              hold_full_q, hold_full_d;
    logic [5:0]        sym_left_q, sym_left_d;
    logic [3:0]        step_q, step_d, osr_cnt_q, osr_cnt_d, idx_q, idx_d;
    logic [7:0]        mod_out_q, mod_out_d;
    logic              mod_valid_q, mod_valid_d, sym_start_q, sym_start_d;
    logic [2:0]        sym_q, sym_d;

    logic              accept, begin_word, next_sym;
    logic [DATA_W-1:0] src_word;
    logic [1:0]        src_bps, cur_bps;
    logic [2:0]        new_sym;
    logic [3:0]        new_phase;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bps_d       = bps_q;
        hold_d      = hold_q;
        hold_mode_d = hold_mode_q;
        hold_full_d = hold_full_q;
        sym_left_d  = sym_left_q;
        step_d      = step_q;
        osr_cnt_d   = osr_cnt_q;
        idx_d       = idx_q;
        mod_out_d   = mod_out_q;
        mod_valid_d = mod_valid_q;
        sym_d       = sym_q;
        sym_start_d = 1'b0;
        begin_word  = 1'b0;
        next_sym    = 1'b0;
        src_word    = parallel_in;
        src_bps     = bps_of(mode);
        cur_bps     = bps_q;
        new_sym     = 3'd0;
        new_phase   = 4'd0;
        accept      = load && !hold_full_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    begin_word = 1'b1;
                    state_d    = RUN;
                end
            end
            default: begin
                if (accept) begin
                    hold_d      = parallel_in;
                    hold_mode_d = mode;
                    hold_full_d = 1'b1;
                end
                if (step_q == 4'd15 && osr_cnt_q == OSR_M1) begin
                    if (sym_left_q != 6'd0) begin
                        next_sym = 1'b1;
                    end else if (hold_full_q) begin
                        // Holding word follows the last sample with no idle cycle.
                        begin_word  = 1'b1;
                        src_word    = hold_q;
                        src_bps     = bps_of(hold_mode_q);
                        hold_full_d = 1'b0;
                    end else begin
                        state_d     = IDLE;
                        mod_out_d   = 8'd128;
                        mod_valid_d = 1'b0;
                        sym_d       = 3'd0;
                    end
                end else if (osr_cnt_q == OSR_M1) begin
                    osr_cnt_d = 4'd0;
                    step_d    = step_q + 4'd1;
                    idx_d     = idx_q + 4'd1;
                    mod_out_d = lut(idx_q + 4'd1);
                end else begin
                    osr_cnt_d = osr_cnt_q + 4'd1;
                end
            end
        endcase

        if (begin_word) begin
            cur_bps    = src_bps;
            new_sym    = sym_of(src_word, src_bps);
            shift_d    = src_word << src_bps;
            bps_d      = src_bps;
            sym_left_d = nsym_of(src_bps) - 6'd1;
        end else if (next_sym) begin
            new_sym    = sym_of(shift_q, bps_q);
            shift_d    = shift_q << bps_q;
            sym_left_d = sym_left_q - 6'd1;
        end

        if (begin_word || next_sym) begin
            new_phase   = phase_of(new_sym, cur_bps);
            idx_d       = new_phase;
            step_d      = 4'd0;
            osr_cnt_d   = 4'd0;
            mod_out_d   = lut(new_phase);
            mod_valid_d = 1'b1;
            sym_d       = new_sym;
            sym_start_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bps_q       <= 2'd1;
            hold_q      <= '0;
            hold_mode_q <= 2'd0;
            hold_full_q <= 1'b0;
            sym_left_q  <= 6'd0;
            step_q      <= 4'd0;
            osr_cnt_q   <= 4'd0;
            idx_q       <= 4'd0;
            mod_out_q   <= 8'd128;
            mod_valid_q <= 1'b0;
            sym_q       <= 3'd0;
            sym_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bps_q       <= bps_d;
            hold_q      <= hold_d;
            hold_mode_q <= hold_mode_d;
            hold_full_q <= hold_full_d;
            sym_left_q  <= sym_left_d;
            step_q      <= step_d;
            osr_cnt_q   <= osr_cnt_d;
            idx_q       <= idx_d;
            mod_out_q   <= mod_out_d;
            mod_valid_q <= mod_valid_d;
            sym_q       <= sym_d;
            sym_start_q <= sym_start_d;
        end
    end

    assign ready     = !hold_full_q;
    assign mod_out   = mod_out_q;
    assign mod_valid = mod_valid_q;
    assign sym_out   = sym_q;
    assign sym_start = sym_start_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_psk_modulator.sv
// Bench for psk_modulator: randomized words scored against a symbol/phase/sine reference
// model (OSR=1 instance), plus a directed OSR=2 instance with mid-symbol reset.
module tb_psk_modulator;

    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst1, d1_load, d1_ready, d1_valid, d1_sym_start, d1_busy;
    logic [DW-1:0] d1_in;
    logic [1:0]    d1_mode;
    logic [7:0]    d1_mod_out;
    logic [2:0]    d1_sym_out;

    logic          rst2, d2_load, d2_ready, d2_valid, d2_sym_start, d2_busy;
    logic [DW-1:0] d2_in;
    logic [1:0]    d2_mode;
    logic [7:0]    d2_mod_out;
    logic [2:0]    d2_sym_out;

    psk_modulator #(.DATA_W(DW), .OSR(1)) u_dut1 (
        .clk(clk), .reset(rst1), .parallel_in(d1_in), .load(d1_load), .mode(d1_mode),
        .ready(d1_ready), .mod_out(d1_mod_out), .mod_valid(d1_valid),
        .sym_out(d1_sym_out), .sym_start(d1_sym_start), .busy(d1_busy)
    );

    psk_modulator #(.DATA_W(DW), .OSR(2)) u_dut2 (
        .clk(clk), .reset(rst2), .parallel_in(d2_in), .load(d2_load), .mode(d2_mode),
        .ready(d2_ready), .mod_out(d2_mod_out), .mod_valid(d2_valid),
        .sym_out(d2_sym_out), .sym_start(d2_sym_start), .busy(d2_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    int lut_t[16] = '{128, 177, 218, 245, 255, 245, 218, 177, 128, 79, 38, 11, 1, 11, 38, 79};
    int ph_b[2]   = '{0, 8};
    int ph_q[4]   = '{0, 4, 12, 8};
    int ph_8[8]   = '{0, 2, 6, 4, 14, 12, 8, 10};

    typedef struct packed {
        logic [7:0] smp;
        logic [2:0] sym;
        logic       st;
    } exp_t;

    exp_t q1[$];

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    endtask

    function automatic int bps_m(input logic [1:0] m);
        return (m == 2'b01) ? 2 : (m == 2'b10) ? 3 : 1;
    endfunction

    function automatic int nsym_m(input logic [1:0] m);
        return (DW + bps_m(m) - 1) / bps_m(m);
    endfunction

    // Sample k of a word: symbol k/SPS built MSB first with zero fill past bit 0.
    function automatic exp_t model(input logic [31:0] w, input logic [1:0] m, input int osr, input int k);
        exp_t r;
        int bps, sps, s, n, sym, p, pos;
        bps = bps_m(m);
        sps = 16 * osr;
        s   = k / sps;
        n   = k % sps;
        sym = 0;
        for (int b = 0; b < bps; b++) begin
            pos = DW - 1 - (s * bps + b);
            sym = sym * 2 + ((pos >= 0) ? int'(w[pos]) : 0);
        end
        p = (bps == 1) ? ph_b[sym] : (bps == 2) ? ph_q[sym] : ph_8[sym];
        r.smp = 8'(lut_t[(n / osr + p) % 16]);
        r.sym = 3'(sym);
        r.st  = (n == 0);
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (d1_valid) begin
                if (q1.size() == 0) begin
                    chk("extra_valid", d1_valid, 0);
                end else begin
                    e = q1.pop_front();
                    chk("mod_out", d1_mod_out, e.smp);
                    chk("sym_out", d1_sym_out, e.sym);
                    chk("sym_start", d1_sym_start, e.st);
                end
            end else begin
                chk("idle_mod_out", d1_mod_out, 128);
                if (q1.size() != 0) chk("gap_valid", d1_valid, 1);
            end
        end
    end

    task automatic send1(input logic [7:0] w, input logic [1:0] m);
        bit   done;
        int   t;
        logic r;
        done = 1'b0;
        t    = 0;
        while (!done) begin
            @(negedge clk);
            r       = d1_ready;
            d1_load = 1'b1;
            if (r) begin
                d1_in   = w;
                d1_mode = m;
            end else begin
                d1_in   = 8'($urandom);
                d1_mode = 2'($urandom);
            end
            @(posedge clk);
            if (r) begin
                for (int k = 0; k < nsym_m(m) * 16; k++) q1.push_back(model(32'(w), m, 1, k));
                done = 1'b1;
            end else if (++t > 3000) begin
                chk("ready_timeout", int'(r), 1);
                done = 1'b1;
            end
        end
        #1;
        d1_load = 1'b0;
        d1_in   = 8'($urandom);
        d1_mode = 2'($urandom);
    endtask

    task automatic wait_idle1();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((q1.size() != 0 || d1_busy) && t < 5000);
        chk("drain", int'(q1.size() == 0 && !d1_busy), 1);
        chk("idle_busy", d1_busy, 0);
        chk("idle_ready", d1_ready, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int   j;
        exp_t e;
        rst1 = 1'b0; d1_load = 1'b1; d1_in = 8'hFF; d1_mode = 2'b00;
        rst2 = 1'b0; d2_load = 1'b0; d2_in = 8'h00; d2_mode = 2'b00;

        // Reset with load held high.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ready", d1_ready, 1);
            chk("rst_mod_out", d1_mod_out, 128);
            chk("rst_valid", d1_valid, 0);
            chk("rst_busy", d1_busy, 0);
            chk("rst_sym_start", d1_sym_start, 0);
            chk("rst_sym_out", d1_sym_out, 0);
        end
        rst1 = 1'b1;
        d1_load = 1'b0;
        mon_en = 1'b1;

        send1(8'b1001_1001, 2'b00);
        wait_idle1();
        send1(8'b0001_1110, 2'b01);
        wait_idle1();
        send1(8'hFF, 2'b10);
        wait_idle1();
        send1(8'h5A, 2'b11);
        wait_idle1();

        // Back-to-back BPSK then QPSK.
        send1(8'hC3, 2'b00);
        send1(8'h2D, 2'b01);
        @(negedge clk);
        chk("ready_low_hold", d1_ready, 0);
        j = 0;
        while (!d1_ready && j < 500) begin
            @(negedge clk);
            j++;
        end
        chk("ready_rise_cycle", j, 127);
        wait_idle1();

        for (int i = 0; i < 30; i++) begin
            send1(8'($urandom), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 0) wait_idle1();
        end
        wait_idle1();

        // OSR=2 instance: held LUT steps, then reset mid-symbol with a word waiting.
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        chk("o2_ready_init", d2_ready, 1);
        d2_in = 8'hA5; d2_mode = 2'b00; d2_load = 1'b1;
        @(posedge clk);
        #1 d2_load = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            e = model(32'h0000_00A5, 2'b00, 2, k);
            chk("o2_mod_out", d2_mod_out, e.smp);
            chk("o2_sym_start", d2_sym_start, e.st);
            chk("o2_valid", d2_valid, 1);
            if (k == 1) begin
                d2_in = 8'h3C; d2_mode = 2'b01; d2_load = 1'b1;
            end
            if (k == 2) d2_load = 1'b0;
            if (k == 4) chk("o2_ready_low", d2_ready, 0);
        end
        rst2 = 1'b0;
        @(negedge clk);
        rst2 = 1'b1;
        chk("o2_rst_mod_out", d2_mod_out, 128);
        chk("o2_rst_valid", d2_valid, 0);
        chk("o2_rst_busy", d2_busy, 0);
        chk("o2_rst_ready", d2_ready, 1);
        chk("o2_rst_sym_start", d2_sym_start, 0);
        repeat (40) @(negedge clk);
        chk("o2_hold_dropped_valid", d2_valid, 0);
        chk("o2_hold_dropped_busy", d2_busy, 0);

        chk("queue_empty", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
